// File: rtl/shared_adder_sched.sv
// shared_adder_sched: round-robin access to one registered W-bit adder.
// IDLE grants and latches operands, EXEC adds, RESP holds result until accepted.
module shared_adder_sched #(
  parameter  int N_REQ = 4,
  parameter  int W     = 4,
  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [W:0]         rsp_sum,
  input  logic               rsp_ready,
  output logic               busy,
  output logic [7:0]         ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_id;
  logic [ID_W-1:0]   id_q;
  logic [N_REQ-1:0]  gnt_vec;
  logic              gnt_any;
  logic [W-1:0]      a_sel;
  logic [W-1:0]      b_sel;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W:0]        sum_q;
  logic [7:0]        cnt_q;
  logic              take;
  logic              hs;

  // First requesting index at or above rr_ptr, wrapping to 0
  always_comb begin : p_arb
    int              idx;
    logic [ID_W-1:0] sel;
    idx     = 0;
    sel     = '0;
    gnt_vec = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    a_sel   = '0;
    b_sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = ID_W'(idx);
      if (!gnt_any && req_valid[sel]) begin
        gnt_any      = 1'b1;
        gnt_id       = sel;
        gnt_vec[sel] = 1'b1;
        a_sel        = req_a[idx*W +: W];
        b_sel        = req_b[idx*W +: W];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    take      = 1'b0;
    hs        = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_any) begin
          take      = 1'b1;
          req_ready = gnt_vec;
          state_nx  = EXEC;
        end
      end
      EXEC: begin
        busy     = 1'b1;
        state_nx = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          hs       = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Capture granted operands and owner ID on the grant edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      id_q <= '0;
    end else if (take) begin
      a_q  <= a_sel;
      b_q  <= b_sel;
      id_q <= gnt_id;
    end
  end

  // Shared adder; carry lands in the top bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                sum_q <= '0;
    else if (state == EXEC) sum_q <= {1'b0, a_q} + {1'b0, b_q};
  end

  // Pointer moves past the owner only once its response is taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      cnt_q  <= '0;
    end else if (hs) begin
      if (int'(id_q) == N_REQ - 1) rr_ptr <= '0;
      else                         rr_ptr <= id_q + 1'b1;
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign rsp_id   = id_q;
  assign rsp_sum  = sum_q;
  assign ops_done = cnt_q;

endmodule

// File: doc/shared_adder_sched.md
# shared_adder_sched

Round-robin scheduler that shares a single registered W-bit adder (c = a + b datapath) among N_REQ requesters. It accepts one operand pair at a time through a valid/ready handshake and runs the addition in a dedicated execute cycle. It returns the sum tagged with the requester ID through a backpressured response port. It sits between the requester blocks and the shared arithmetic datapath, so only one requester drives the adder at any time.

## Interface
- N_REQ, 4: number of requesters (2..8).
- W, 4: operand width in bits.
- ID_W, $clog2(N_REQ): requester ID width (derived, not overridden).
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- req_valid  in  N_REQ  bit i set = requester i presents an operand pair.
- req_a  in  N_REQ*W  operand a; requester i owns bits [i*W +: W].
- req_b  in  N_REQ*W  operand b; same packing as req_a.
- req_ready  out  N_REQ  one-hot grant; bit i high = requester i's operands are captured this cycle.
- rsp_valid  out  1  result available.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_sum  out  W+1  a + b; bit W is the carry-out.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in EXEC and RESP.
- ops_done  out  8  count of completed responses; wraps 255 -> 0.

## Operation
- FSM states:
  - IDLE -> EXEC when any req_valid bit is set.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE on rsp_valid && rsp_ready.
- Arbitration happens only in IDLE. The grant g is the first set bit of req_valid, searching upward from rr_ptr and wrapping from N_REQ-1 to 0.
- req_ready[g] is combinational, is high only in IDLE, and is one-hot or zero. Operands a[g] and b[g] and the ID g are latched on that edge.
- EXEC: the adder computes a + b zero-extended to W+1 bits, and the result is registered into rsp_sum. There is no saturation; the carry appears in bit W.
- RESP: rsp_valid=1. rsp_id and rsp_sum are held stable until the handshake completes.
- On the RESP handshake:
  - rr_ptr <= (g+1) mod N_REQ.
  - ops_done increments.
- rr_ptr advances only on a completed response, never on a grant alone.
- A requester may drop req_valid while not granted, with no side effect. Once the requester is granted, the latched operands are used even if its inputs change later.
- Requests that arrive while busy are ignored until the FSM returns to IDLE.
- Reset, including reset asserted mid-operation:
  - State returns to IDLE and any in-flight operation is discarded with no response.
  - rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, busy=0, ops_done=0.

## Timing
- Grant at edge T (IDLE with req_valid[g] high). EXEC occupies cycle T+1. rsp_valid rises after edge T+2.
- Minimum time from grant to next grant is 3 cycles, which requires rsp_ready high at the first RESP cycle.
- Each cycle rsp_ready stays low adds one cycle to that operation's latency.
- If rsp_ready is already high when RESP is entered, the handshake completes in that single RESP cycle.
- The next grant can occur in the IDLE cycle immediately after the handshake.
- After rst deasserts, the first grant is possible on the first clk edge.
- Simultaneous rsp_ready and new req_valid in RESP: the response completes, and the new request waits for IDLE on the following cycle.

## Test plan
- Single request:
  - Stimulus: req_valid=4'b0001, a0=3, b0=5.
  - Required: req_ready=4'b0001 for exactly one cycle; rsp_valid after 2 edges with rsp_id=0, rsp_sum=5'd8; ops_done=1.
- Overflow:
  - Stimulus: requester 2 with a=15, b=15.
  - Required: rsp_sum=5'b11110 (30), rsp_id=2.
- Round-robin fairness:
  - Stimulus: req_valid=4'b1111 held, rsp_ready=1.
  - Required: grants in order 0,1,2,3,0; 5 responses in 15 cycles.
- Backpressure:
  - Stimulus: rsp_ready=0 for 4 cycles in RESP while requester 1 is requesting.
  - Required: rsp_sum and rsp_id stable; req_ready stays 0; requester 1 is granted the cycle after the handshake.
- Reset mid-operation:
  - Stimulus: assert rst in EXEC.
  - Required: immediately rsp_valid=0, busy=0, ops_done=0, rr_ptr=0; no response is ever issued for the discarded operation.
- Counter wrap:
  - Stimulus: 256 back-to-back operations.
  - Required: ops_done returns to 0.
